// File: rtl/alu_flag_if.sv
// alu_flag_if: request/response bundle between the execute stage (master) and alu_flag_unit (slave); i_* are requests, o_* are results and flags
interface alu_flag_if #(parameter int WIDTH = 16);
  logic             i_start;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_result_we;
  logic             o_flag_we;
  logic             o_flag_f;
  logic             o_flag_l;
  logic             o_flag_n;
  logic             o_flag_z;
  modport master (output i_start, i_op, i_a, i_b,
                  input  o_busy, o_done, o_result, o_result_we, o_flag_we, o_flag_f, o_flag_l, o_flag_n, o_flag_z);
  modport slave  (input  i_start, i_op, i_a, i_b,
                  output o_busy, o_done, o_result, o_result_we, o_flag_we, o_flag_f, o_flag_l, o_flag_n, o_flag_z);
endinterface

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: 16-bit ALU with F/L/N/Z flags and write enables; ports clk, reset (sync, active-high), bus (alu_flag_if.slave)
module alu_flag_unit #(parameter int WIDTH = 16) (
  input logic       clk,
  input logic       reset,
  alu_flag_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_AND = 4'd3,
                         OP_OR = 4'd4, OP_XOR = 4'd5, OP_LSH = 4'd6, OP_MUL = 4'd7;
  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_result;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done, r_rwe, r_fwe, r_f, r_l, r_n, r_z;
  logic [WIDTH:0]     w_sum, w_diff, w_madd;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_shl, w_res;
  logic               w_ovf_add, w_ovf_sub, w_iter, w_cmp, w_fin;
  logic               w_f, w_l, w_n, w_z, w_rwe, w_fwe;
  assign w_sum     = {1'b0, bus.i_a} + {1'b0, bus.i_b};
  assign w_diff    = {1'b0, bus.i_a} - {1'b0, bus.i_b};
  assign w_ovf_add = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.i_a[WIDTH-1]);
  assign w_ovf_sub = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.i_a[WIDTH-1]);
  assign w_iter    = bus.i_op == OP_MUL || (bus.i_op == OP_LSH && bus.i_b[3:0] != 4'd0);
  assign w_cmp     = r_state == S_IDLE && bus.i_op == OP_CMP;
  // Right-shifting shift-add: the upper half accumulates, the finished low bits walk down.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_b[0]}} & r_a};
  assign w_acc     = {w_madd, r_acc[WIDTH-1:1]};
  assign w_shl     = {r_a[WIDTH-2:0], 1'b0};
  always_comb begin
    w_res = r_result;
    w_f   = 1'b0;
    w_l   = 1'b0;
    w_rwe = 1'b1;
    w_fwe = 1'b1;
    w_fin = 1'b0;
    if (r_state == S_SHIFT) begin
      w_fin = r_cnt == 4'd1;
      w_res = w_shl;
      w_l   = r_a[WIDTH-1];
    end else if (r_state == S_MUL) begin
      w_fin = r_cnt == 4'd15;
      w_res = w_acc[WIDTH-1:0];
      w_f   = |w_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_fin = bus.i_start && !w_iter;
      case (bus.i_op)
        OP_ADD: begin w_res = w_sum[WIDTH-1:0]; w_l = w_sum[WIDTH]; w_f = w_ovf_add; end
        OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_l = w_diff[WIDTH]; w_f = w_ovf_sub; end
        OP_CMP: begin w_l = w_diff[WIDTH]; w_f = w_ovf_sub; w_rwe = 1'b0; end
        OP_AND: w_res = bus.i_a & bus.i_b;
        OP_OR:  w_res = bus.i_a | bus.i_b;
        OP_XOR: w_res = bus.i_a ^ bus.i_b;
        OP_LSH: w_res = bus.i_a;
        default: begin w_res = '0; w_rwe = 1'b0; w_fwe = 1'b0; end
      endcase
    end
    // CMP reports signed less-than and equality rather than properties of a-b.
    w_n = w_cmp ? w_diff[WIDTH-1] ^ w_ovf_sub : w_res[WIDTH-1];
    w_z = w_cmp ? bus.i_a == bus.i_b : ~|w_res;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_rwe    <= 1'b0;
      r_fwe    <= 1'b0;
      {r_f, r_l, r_n, r_z} <= 4'b0;
    end else begin
      r_done <= w_fin;
      r_rwe  <= w_fin && w_rwe;
      r_fwe  <= w_fin && w_fwe;
      if (w_fin) r_result <= w_res;
      if (w_fin && w_fwe) {r_f, r_l, r_n, r_z} <= {w_f, w_l, w_n, w_z};
      if (r_state == S_IDLE) begin
        if (bus.i_start && w_iter) begin
          r_a     <= bus.i_a;
          r_b     <= bus.i_b;
          r_acc   <= '0;
          r_cnt   <= bus.i_op == OP_MUL ? 4'd0 : bus.i_b[3:0];
          r_state <= bus.i_op == OP_MUL ? S_MUL : S_SHIFT;
        end
      end else begin
        r_cnt <= r_state == S_SHIFT ? r_cnt - 4'd1 : r_cnt + 4'd1;
        r_a   <= r_state == S_SHIFT ? w_shl : r_a;
        r_acc <= w_acc;
        r_b   <= r_b >> 1;
        if (w_fin) r_state <= S_IDLE;
      end
    end
  end
  assign bus.o_busy      = r_state != S_IDLE;
  assign bus.o_done      = r_done;
  assign bus.o_result    = r_result;
  assign bus.o_result_we = r_rwe;
  assign bus.o_flag_we   = r_fwe;
  assign bus.o_flag_f    = r_f;
  assign bus.o_flag_l    = r_l;
  assign bus.o_flag_n    = r_n;
  assign bus.o_flag_z    = r_z;
endmodule
